// File: rtl/memcard_responder.sv
// Card-side SD/MMC CMD line responder: samples host command frames, checks CRC7,
// hands the command to the user and serialises a 48-bit response after the Ncr gap.
module memcard_responder #(
    parameter int NCR_CYCLES = 2,
    parameter int NCR_MAX    = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        mc_clk,
    input  logic        mc_cmd_i,
    output logic        mc_cmd_o,
    output logic        mc_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_err,
    input  logic        rsp_valid,
    input  logic        rsp_none,
    output logic        rsp_ready,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_arg,
    output logic        rsp_missed,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, NCR, TX} state_t;

    localparam logic [5:0] NCR_LAST = 6'(NCR_MAX - 1);
    localparam logic [5:0] NCR_MIN  = 6'(NCR_CYCLES);

    // x^7 + x^3 + 1, MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        return {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? 7'h09 : 7'h00);
    endfunction

    logic [1:0]  clk_sync_q, clk_sync_d, cmd_sync_q, cmd_sync_d;
    logic        clk_prev_q, clk_prev_d;
    state_t      state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d, ncr_cnt_q, ncr_cnt_d;
    logic [47:0] shift_q, shift_d;
    logic [6:0]  crc_q, crc_d;
    logic        cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
    logic        cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        rsp_missed_q, rsp_missed_d, rsp_ready_q, rsp_ready_d, busy_q, busy_d;
    logic        rise, fall, bit_in, frame_err;
    logic [47:0] frame;
    logic [5:0]  ncr_inc;

    assign rise      = clk_sync_q[1] & ~clk_prev_q;
    assign fall      = ~clk_sync_q[1] & clk_prev_q;
    assign bit_in    = cmd_sync_q[1];
    assign frame     = {shift_q[46:0], bit_in};
    assign frame_err = ~frame[46] | (frame[7:1] != crc_q) | ~frame[0];
    assign ncr_inc   = (ncr_cnt_q == 6'd63) ? ncr_cnt_q : ncr_cnt_q + 6'd1;

    always_comb begin
        clk_sync_d   = {clk_sync_q[0], mc_clk};
        cmd_sync_d   = {cmd_sync_q[0], mc_cmd_i};
        clk_prev_d   = clk_sync_q[1];
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        ncr_cnt_d    = ncr_cnt_q;
        shift_d      = shift_q;
        crc_d        = crc_q;
        cmd_o_d      = cmd_o_q;
        cmd_oe_d     = cmd_oe_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = cmd_err_q;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        rsp_missed_d = 1'b0;
        case (state_q)
            IDLE: if (rise && !bit_in) begin
                state_d  = RX;
                bitcnt_d = 6'd1;
                shift_d  = '0;
                crc_d    = crc7_step(7'd0, bit_in);
            end
            RX: if (rise) begin
                shift_d  = frame;
                bitcnt_d = bitcnt_q + 6'd1;
                if (bitcnt_q < 6'd40) crc_d = crc7_step(crc_q, bit_in);
                if (bitcnt_q == 6'd47) begin
                    cmd_valid_d = 1'b1;
                    cmd_err_d   = frame_err;
                    cmd_index_d = frame[45:40];
                    cmd_arg_d   = frame[39:8];
                    bitcnt_d    = '0;
                    ncr_cnt_d   = '0;
                    state_d     = frame_err ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rise) ncr_cnt_d = ncr_inc;
                // a response offered on the timeout edge still wins
                if (rsp_valid && rsp_none) begin
                    state_d = IDLE;
                end else if (rsp_valid) begin
                    shift_d = {2'b00, rsp_index, rsp_arg, 8'h00};
                    state_d = NCR;
                end else if (rise && ncr_cnt_q == NCR_LAST) begin
                    rsp_missed_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            NCR: begin
                if (rise) ncr_cnt_d = ncr_inc;
                if (fall && ncr_cnt_q >= NCR_MIN) begin
                    state_d  = TX;
                    cmd_oe_d = 1'b1;
                    cmd_o_d  = shift_q[47];
                    crc_d    = crc7_step(7'd0, shift_q[47]);
                    shift_d  = {shift_q[46:0], 1'b0};
                    bitcnt_d = 6'd1;
                end
            end
            TX: if (fall) begin
                bitcnt_d = bitcnt_q + 6'd1;
                if (bitcnt_q < 6'd40) begin
                    cmd_o_d = shift_q[47];
                    crc_d   = crc7_step(crc_q, shift_q[47]);
                    shift_d = {shift_q[46:0], 1'b0};
                end else if (bitcnt_q < 6'd47) begin
                    cmd_o_d = crc_q[6];
                    crc_d   = {crc_q[5:0], 1'b0};
                end else if (bitcnt_q == 6'd47) begin
                    cmd_o_d = 1'b1;
                end else begin
                    cmd_oe_d = 1'b0;
                    cmd_o_d  = 1'b1;
                    bitcnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_ready_d = (state_d == WAIT_RSP);
        busy_d      = (state_d != IDLE);
    end

    // CMD sync resets high so a reset never manufactures a start bit
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_sync_q   <= 2'b00;
            cmd_sync_q   <= 2'b11;
            clk_prev_q   <= 1'b0;
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            ncr_cnt_q    <= '0;
            shift_q      <= '0;
            crc_q        <= '0;
            cmd_o_q      <= 1'b1;
            cmd_oe_q     <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            rsp_missed_q <= 1'b0;
            rsp_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            cmd_sync_q   <= cmd_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            ncr_cnt_q    <= ncr_cnt_d;
            shift_q      <= shift_d;
            crc_q        <= crc_d;
            cmd_o_q      <= cmd_o_d;
            cmd_oe_q     <= cmd_oe_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            rsp_missed_q <= rsp_missed_d;
            rsp_ready_q  <= rsp_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign mc_cmd_o   = cmd_o_q;
    assign mc_cmd_oe  = cmd_oe_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_err    = cmd_err_q;
    assign cmd_index  = cmd_index_q;
    assign cmd_arg    = cmd_arg_q;
    assign rsp_missed = rsp_missed_q;
    assign rsp_ready  = rsp_ready_q;
    assign busy       = busy_q;
endmodule
